// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the instruction-ROM byte-stream loader.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

  localparam int unsigned ROM_WORD_BYTES = 4;
  localparam logic [31:0] ROM_ADDR_STEP  = 32'd4;

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input, ROM write port and load status of the instruction-ROM loader.
interface rom_loader_if;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        wen_o;
  logic [31:0] w_addr_o;
  logic [31:0] w_data_o;
  logic        cpu_hold_o;
  logic        load_done_o;
  logic        load_err_o;

  modport master (
    output start_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, wen_o, w_addr_o, w_data_o, cpu_hold_o, load_done_o, load_err_o
  );

  modport slave (
    input  start_i, byte_valid_i, byte_data_i,
    output byte_ready_o, wen_o, w_addr_o, w_data_o, cpu_hold_o, load_done_o, load_err_o
  );
endinterface

// File: rtl/rom_loader_word_asm.sv
// Little-endian byte-to-word assembler shared by the header and payload phases.
module rom_loader_word_asm
  import rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  idx_reg;
  logic [31:0] shift_reg;

  // Newest byte enters at the top, so after four bytes the first one sits in [7:0].
  assign word      = {byte_data, shift_reg[31:8]};
  assign word_done = byte_en && (idx_reg == 2'(ROM_WORD_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg   <= 2'd0;
      shift_reg <= 32'd0;
    end else if (clear) begin
      idx_reg   <= 2'd0;
    end else if (byte_en) begin
      idx_reg   <= idx_reg + 2'd1;
      shift_reg <= word;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Framed byte-stream loader for the instruction ROM; holds the core until the image is written.
// Optional trailing XOR checksum byte is enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic         clk,
  input logic         rst,
  rom_loader_if.slave bus
);

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_e FRAME_END = CSUM;
  logic [7:0] csum_reg;
`else
  localparam state_e FRAME_END = DONE;
`endif

  state_e      state_reg, state_next;
  logic [31:0] addr_reg, count_reg, words_reg, idle_reg;
  logic [31:0] w_addr_reg, w_data_reg;
  logic        done_reg, err_reg;
  logic        ready, hold, accept, start_go, timeout, asm_en, word_done;
  logic [31:0] word;

  assign ready    = (state_reg == HDR) || (state_reg == DATA) || (state_reg == CSUM);
  assign hold     = ready || (state_reg == WRITE);
  assign accept   = ready && bus.byte_valid_i;
  assign start_go = bus.start_i && !hold;
  assign timeout  = ready && !accept && (idle_reg == 32'(TIMEOUT_CYCLES - 1));
  assign asm_en   = accept && ((state_reg == HDR) || (state_reg == DATA));

  rom_loader_word_asm u_word_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_go),
    .byte_en   (asm_en),
    .byte_data (bus.byte_data_i),
    .word      (word),
    .word_done (word_done)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR: if (start_go) state_next = HDR;
      HDR: begin
        if (timeout)                         state_next = ERR;
        else if (word_done) begin
          if (word > 32'(MAX_WORDS))         state_next = ERR;
          else if (word == 32'd0)            state_next = FRAME_END;
          else                               state_next = DATA;
        end
      end
      DATA: begin
        if (timeout)                         state_next = ERR;
        else if (word_done)                  state_next = WRITE;
      end
      WRITE: begin
        if (words_reg + 32'd1 == count_reg)  state_next = FRAME_END;
        else                                 state_next = DATA;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (timeout)                         state_next = ERR;
        else if (accept)                     state_next = (bus.byte_data_i == csum_reg) ? DONE : ERR;
      end
`endif
      default:                               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= 32'd0;
      count_reg  <= 32'd0;
      words_reg  <= 32'd0;
      idle_reg   <= 32'd0;
      w_addr_reg <= 32'd0;
      w_data_reg <= 32'd0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_go) begin
        addr_reg  <= ADDR_BASE;
        words_reg <= 32'd0;
        done_reg  <= 1'b0;
        err_reg   <= 1'b0;
      end
      // The write cycle is not idle time on the input stream.
      if (start_go || accept || state_reg == WRITE)
        idle_reg <= 32'd0;
      else if (ready)
        idle_reg <= idle_reg + 32'd1;
      if (state_reg == HDR && word_done)
        count_reg <= word;
      if (state_reg == DATA && word_done) begin
        w_addr_reg <= addr_reg;
        w_data_reg <= word;
      end
      if (state_reg == WRITE) begin
        addr_reg  <= addr_reg + ROM_ADDR_STEP;
        words_reg <= words_reg + 32'd1;
      end
      if (state_next == DONE && state_reg != DONE) done_reg <= 1'b1;
      if (state_next == ERR  && state_reg != ERR)  err_reg  <= 1'b1;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      csum_reg <= 8'h00;
    else if (start_go)
      csum_reg <= 8'h00;
    else if (state_reg == DATA && accept)
      csum_reg <= csum_reg ^ bus.byte_data_i;
  end
`endif

  assign bus.byte_ready_o = ready;
  assign bus.wen_o        = (state_reg == WRITE);
  assign bus.w_addr_o     = w_addr_reg;
  assign bus.w_data_o     = w_data_reg;
  assign bus.cpu_hold_o   = hold;
  assign bus.load_done_o  = done_reg;
  assign bus.load_err_o   = err_reg;

endmodule
